// File: rtl/control_fsm.sv
// Multi-cycle MIPS main control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK walk plus retired-instruction counter.
// Define CONTROL_FSM_ILLEGAL_TRAP_EN to trap on unsupported opcodes; otherwise they retire as 3-cycle NOPs.
module control_fsm #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned RETIRE_WIDTH = 32
) (
  input  logic                    cu_clk,
  input  logic                    cu_rst,
  input  logic                    cu_i_en,
  input  logic [OPCODE_WIDTH-1:0] cu_i_opcode,
  output logic                    cu_o_ce,
  output logic                    cu_o_RegDst,
  output logic                    cu_o_RegWrite,
  output logic                    cu_o_ALUSrc,
  output logic                    cu_o_Branch,
  output logic                    cu_o_MemRead,
  output logic                    cu_o_MemWrite,
  output logic                    cu_o_MemtoReg,
  output logic                    cu_o_Jump,
  output logic                    cu_o_busy,
  output logic [2:0]              cu_o_state,
  output logic [RETIRE_WIDTH-1:0] cu_o_retired,
  output logic                    cu_o_illegal
);

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    retire;

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction
`endif

  // State, latched opcode and retire counter
  always_ff @(posedge cu_clk) begin
    if (!cu_rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

  // Next-state; the opcode is only captured on the DECODE->EXECUTE edge
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    retire   = 1'b0;
    unique case (state_q)
      S_IDLE:   if (cu_i_en) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
        if (op_legal(cu_i_opcode)) begin
          state_d  = S_EXECUTE;
          opcode_d = cu_i_opcode;
        end else begin
          state_d  = S_TRAP;
        end
`else
        state_d  = S_EXECUTE;
        opcode_d = cu_i_opcode;
`endif
      end
      S_EXECUTE: begin
        if (opcode_q == OP_LW || opcode_q == OP_SW)          state_d = S_MEMORY;
        else if (opcode_q == OP_RTYPE || opcode_q == OP_ADDI) state_d = S_WRITEBACK;
        else                                                  retire  = 1'b1;
      end
      S_MEMORY: begin
        if (opcode_q == OP_LW) state_d = S_WRITEBACK;
        else                   retire  = 1'b1;
      end
      S_WRITEBACK: retire = 1'b1;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_IDLE;
    endcase
    if (retire) state_d = cu_i_en ? S_FETCH : S_IDLE;
    retired_d = retire ? retired_q + RETIRE_WIDTH'(1) : retired_q;
  end

  // Moore output decode from state and latched opcode
  always_comb begin
    cu_o_ce       = 1'b0;
    cu_o_RegDst   = 1'b0;
    cu_o_RegWrite = 1'b0;
    cu_o_ALUSrc   = 1'b0;
    cu_o_Branch   = 1'b0;
    cu_o_MemRead  = 1'b0;
    cu_o_MemWrite = 1'b0;
    cu_o_MemtoReg = 1'b0;
    cu_o_Jump     = 1'b0;
    if (state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK) begin
      cu_o_ALUSrc = (opcode_q == OP_LW) || (opcode_q == OP_SW) || (opcode_q == OP_ADDI);
      cu_o_RegDst = (opcode_q == OP_RTYPE);
    end
    unique case (state_q)
      S_FETCH:     cu_o_ce = 1'b1;
      S_EXECUTE: begin
        cu_o_Branch = (opcode_q == OP_BEQ);
        cu_o_Jump   = (opcode_q == OP_J);
      end
      S_MEMORY: begin
        cu_o_MemRead  = (opcode_q == OP_LW);
        cu_o_MemWrite = (opcode_q == OP_SW);
      end
      S_WRITEBACK: begin
        cu_o_RegWrite = 1'b1;
        cu_o_MemtoReg = (opcode_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign cu_o_busy    = (state_q != S_IDLE);
  assign cu_o_state   = state_q;
  assign cu_o_retired = retired_q;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  assign cu_o_illegal = (state_q == S_TRAP);
`else
  assign cu_o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Randomized self-checking bench for control_fsm against a per-instruction phase model.
// Honours CONTROL_FSM_ILLEGAL_TRAP_EN to pick the expected illegal-opcode behaviour.
module tb_control_fsm;
  localparam int unsigned OW = 6;
  localparam int unsigned RW = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [OW-1:0] opcode;
  logic ce, regdst, regwrite, alusrc, branch, memread, memwrite, memtoreg, jump, busy, illegal;
  logic [2:0]    st;
  logic [RW-1:0] ret;

  control_fsm #(.OPCODE_WIDTH(OW), .RETIRE_WIDTH(RW)) dut (
    .cu_clk(clk), .cu_rst(rst_n), .cu_i_en(en), .cu_i_opcode(opcode),
    .cu_o_ce(ce), .cu_o_RegDst(regdst), .cu_o_RegWrite(regwrite), .cu_o_ALUSrc(alusrc),
    .cu_o_Branch(branch), .cu_o_MemRead(memread), .cu_o_MemWrite(memwrite),
    .cu_o_MemtoReg(memtoreg), .cu_o_Jump(jump), .cu_o_busy(busy),
    .cu_o_state(st), .cu_o_retired(ret), .cu_o_illegal(illegal)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [RW-1:0] m_ret    = '0;

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  function automatic bit traps(input logic [5:0] op);
    return TRAP_EN && !is_legal(op);
  endfunction

  // Cycles from FETCH to last state; illegal opcodes are 3 (NOP) or park in TRAP at the third
  function automatic int instr_len(input logic [5:0] op);
    case (op)
      OP_LW:                     return 5;
      OP_R, OP_SW, OP_ADDI:      return 4;
      default:                   return 3;
    endcase
  endfunction

  function automatic int phase_at(input logic [5:0] op, input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return traps(op) ? 6 : 3;
      3:       return (op == OP_LW || op == OP_SW) ? 4 : 5;
      default: return 5;
    endcase
  endfunction

  // {ce,RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg,Jump,busy,illegal}
  function automatic logic [10:0] exp_ctrl(input int ph, input logic [5:0] op);
    logic in_exe;
    in_exe = (ph >= 3 && ph <= 5);
    return {ph == 1,
            in_exe && op == OP_R,
            ph == 5,
            in_exe && (op == OP_LW || op == OP_SW || op == OP_ADDI),
            ph == 3 && op == OP_BEQ,
            ph == 4 && op == OP_LW,
            ph == 4 && op == OP_SW,
            ph == 5 && op == OP_LW,
            ph == 3 && op == OP_J,
            ph != 0,
            ph == 6};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int ph, input logic [5:0] op);
    logic [10:0] act, exp;
    act = {ce, regdst, regwrite, alusrc, branch, memread, memwrite, memtoreg, jump, busy, illegal};
    exp = exp_ctrl(ph, op);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s ctrl op=%b: observed %b expected %b", tag, op, act, exp);
    end
    n_assert++;
    assert (st === 3'(ph)) else begin
      n_fail++;
      $error("FAIL %s state op=%b: observed %0d expected %0d", tag, op, st, ph);
    end
    n_assert++;
    assert (ret === m_ret) else begin
      n_fail++;
      $error("FAIL %s retired op=%b: observed %0d expected %0d", tag, op, ret, m_ret);
    end
  endtask

  // Walk one instruction from FETCH; max_ph>0 stops early with the DUT sitting in that next phase
  task automatic run_instr(input string tag, input logic [5:0] op, input logic end_en, input int max_ph);
    int n, lim, ph;
    n   = instr_len(op);
    lim = (max_ph > 0 && max_ph < n) ? max_ph : n;
    for (int i = 0; i < lim; i++) begin
      ph     = phase_at(op, i);
      opcode = (ph == 2) ? op : OW'($urandom);
      en     = (i == n - 1) ? end_en : 1'($urandom);
      check(tag, ph, op);
      tick();
    end
    if (lim == n && !traps(op)) m_ret++;
  endtask

  task automatic idle_then_start(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0;
      opcode = OW'($urandom);
      check("idle", 0, OP_R);
      tick();
    end
    en = 1'b1;
    check("idle_go", 0, OP_R);
    tick();
  endtask

  logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  initial begin
    logic [5:0] op;
    logic       e;

    // Reset held two cycles with run enable high
    rst_n = 1'b0; en = 1'b1; opcode = OP_LW;
    tick(); check("reset1", 0, OP_R);
    tick(); check("reset2", 0, OP_R);
    rst_n = 1'b1;
    idle_then_start(0);

    run_instr("lw", OP_LW, 1'b1, 0);
    run_instr("seq_r", OP_R, 1'b1, 0);
    run_instr("seq_sw", OP_SW, 1'b1, 0);
    run_instr("seq_beq", OP_BEQ, 1'b1, 0);
    run_instr("seq_j", OP_J, 1'b1, 0);
    run_instr("seq_addi", OP_ADDI, 1'b0, 0);
    idle_then_start(2);

    // Enable dropped mid R-type: still writes back, then idles
    run_instr("r_en_drop", OP_R, 1'b0, 0);
    check("after_drop", 0, OP_R);
    idle_then_start(1);

    for (int k = 0; k < 300; k++) begin
      op = ops[$urandom_range(0, 5)];
      if (!TRAP_EN && $urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        if (is_legal(op)) op = 6'b111110;
      end
      e = ($urandom_range(0, 3) != 0);
      run_instr("rand", op, e, 0);
      if (!e) idle_then_start($urandom_range(0, 3));
    end

    // Drive the counter to all-ones, then one beq wraps it
    for (int k = 0; k < 256 && m_ret != '1; k++) run_instr("fill", OP_BEQ, 1'b1, 0);
    run_instr("wrap_beq", OP_BEQ, 1'b1, 0);
    check("wrapped", 1, OP_R);

    // Reset landing in sw's MEMORY cycle
    run_instr("sw_pre", OP_SW, 1'b1, 3);
    check("sw_mem", 4, OP_SW);
    rst_n = 1'b0;
    tick();
    m_ret = '0;
    check("sw_reset", 0, OP_R);
    rst_n = 1'b1;
    idle_then_start(0);

    // Unsupported opcode
    run_instr("illegal", 6'b111111, 1'b0, 0);
    if (TRAP_EN) begin
      for (int k = 0; k < 12; k++) begin
        en = 1'($urandom);
        opcode = OW'($urandom);
        check("trap_hold", 6, 6'b111111);
        tick();
      end
      rst_n = 1'b0;
      tick();
      m_ret = '0;
      rst_n = 1'b1;
    end
    check("illegal_end", 0, OP_R);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle main control unit that sits directly upstream of the MIPS datapath and drives its control inputs (clock-enable, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg) plus a jump strobe. It walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It decodes the opcode the datapath's decoder stage returns. It also keeps a retired-instruction counter for bring-up and performance checks.

## Interface
- OPCODE_WIDTH, 6, opcode field width
- RETIRE_WIDTH, 32, retired-instruction counter width
- cu_clk  input  1  clock; all state updates on rising edge
- cu_rst  input  1  reset, synchronous, active-low
- cu_i_en  input  1  run enable; sampled in IDLE and at instruction end
- cu_i_opcode  input  OPCODE_WIDTH  opcode from decoder stage, valid in DECODE
- cu_o_ce  output  1  datapath clock-enable (PC advance / fetch)
- cu_o_RegDst, cu_o_RegWrite, cu_o_ALUSrc, cu_o_Branch, cu_o_MemRead, cu_o_MemWrite, cu_o_MemtoReg  output  1 each  datapath controls
- cu_o_Jump  output  1  unconditional jump strobe
- cu_o_busy  output  1  high in any state except IDLE
- cu_o_state  output  3  current state encoding
- cu_o_retired  output  RETIRE_WIDTH  retired-instruction count
- cu_o_illegal  output  1  illegal-opcode flag (see Configuration)

## Operation
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6. Encoding 7 is unreachable and recovers to IDLE.
- Supported opcodes:
  - R-type 6'b000000
  - lw 6'b100011
  - sw 6'b101011
  - beq 6'b000100
  - addi 6'b001000
  - j 6'b000010
- Opcode register: loaded from cu_i_opcode on the DECODE→EXECUTE edge only. Outputs in EXECUTE and later decode from this register, never from the live input.
- Transitions:
  - IDLE→FETCH when cu_i_en=1.
  - FETCH→DECODE.
  - DECODE→EXECUTE.
  - EXECUTE→MEMORY for lw/sw.
  - EXECUTE→WRITEBACK for R-type/addi.
  - beq/j retire from EXECUTE.
  - MEMORY→WRITEBACK for lw; sw retires from MEMORY.
  - WRITEBACK retires.
- On retire: go to FETCH if cu_i_en=1, else IDLE. cu_i_en is ignored mid-instruction.
- Output decode (Moore; all outputs 0 unless listed):
  - FETCH: cu_o_ce=1.
  - EXECUTE, MEMORY and WRITEBACK: cu_o_ALUSrc=1 for lw/sw/addi; cu_o_RegDst=1 for R-type.
  - EXECUTE only: cu_o_Branch=1 for beq; cu_o_Jump=1 for j.
  - MEMORY: cu_o_MemRead=1 for lw; cu_o_MemWrite=1 for sw.
  - WRITEBACK: cu_o_RegWrite=1; cu_o_MemtoReg=1 for lw.
- MemRead and MemWrite are never high together. RegWrite is high exactly one cycle per R-type/lw/addi instruction.
- cu_o_retired: +1 on the clock edge that leaves an instruction's final state. Wraps from 2^RETIRE_WIDTH−1 to 0. Does not count illegal opcodes.

## Timing
- Reset (cu_rst=0 at a rising edge), all of:
  - state=IDLE
  - opcode register=0
  - cu_o_retired=0
  - cu_o_illegal=0
  - all control outputs=0, cu_o_busy=0
- Reset overrides every other event, including mid-instruction. Any in-flight MemWrite/RegWrite drops to 0 in the cycle after the reset edge.
- Cycles per instruction, FETCH to last state inclusive: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
- First FETCH is one cycle after cu_i_en is seen high in IDLE. Back-to-back instructions have no IDLE gap while cu_i_en=1.
- Outputs change only on cu_clk edges and follow the state register combinationally; no extra output pipeline stage.

## Configuration
- Macro: CONTROL_FSM_ILLEGAL_TRAP_EN.
- With the macro defined:
  - An unsupported opcode in DECODE sends the FSM to TRAP.
  - TRAP sets cu_o_illegal=1, keeps cu_o_busy=1 and all controls at 0.
  - TRAP is held until reset; the retired count is unchanged.
- Without the macro:
  - An unsupported opcode executes as a NOP: DECODE→EXECUTE with no controls asserted, then retires from EXECUTE (3 cycles, counted).
  - cu_o_illegal is tied to 0 and TRAP is unreachable.

## Test plan
- Reset with cu_rst=0 for 2 cycles, cu_i_en=1 → state=0, cu_o_retired=0, every control output 0 throughout reset.
- lw (100011), cu_i_en=1 → ce in cycle 1, ALUSrc in cycles 3–5, MemRead in cycle 4, RegWrite+MemtoReg in cycle 5, retired=1, next state FETCH.
- Sequence R-type, sw, beq, j, addi → per-instruction lengths 4/4/3/3/4 (18 cycles total), retired=5, MemWrite only during sw's MEMORY cycle, Branch/Jump one cycle each.
- Opcode 6'b111111, macro defined → state=6, cu_o_illegal=1 held for 10+ cycles, retired unchanged. Macro undefined → 3-cycle NOP, retired increments.
- cu_i_en dropped during EXECUTE of an R-type → WRITEBACK still completes with RegWrite=1, then IDLE, busy=0.
- Preload retired=0xFFFFFFFF via forced run, then retire one beq → retired=0. Reset asserted in MEMORY of sw → MemWrite=0 the next cycle, state=IDLE.
